// File: rtl/led_pwm_ctrl.sv
// Multi-channel LED driver: per-channel off / on / blink / PWM, set through a small register port.
// Latency: led_out and cfg_rdata are registered, one cycle after counter/cfg/address state.
// Backpressure: none; every write is taken on its strobe cycle and reads are returned every cycle.
module led_pwm_ctrl #(
  parameter int CH_NUM         = 4,
  parameter int CNT_W          = 32,
  parameter int PRESCALE       = 25,
  parameter int PWM_W          = 8,
  parameter bit LED_ACTIVE_LOW = 1'b0,
  localparam int AW            = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic              fpga_clk_in,
  input  logic              fpga_rst_n,
  input  logic              cfg_wr_en,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [15:0]       cfg_wdata,
  output logic [15:0]       cfg_rdata,
  output logic              pwm_tick,
  output logic [CH_NUM-1:0] led_out
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  // Config word layout: [1:0] mode, [6:2] blink_sel, [7] reserved, [15:8] duty.
  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_PWM   = 2'b11;

  logic [CNT_W-1:0]  led_cnt;
  logic [PRE_W-1:0]  pre_cnt;
  logic [PWM_W-1:0]  pwm_cnt;
  logic [15:0]       cfg [CH_NUM];
  logic              pre_wrap;
  logic [15:0]       rd_sel;
  logic [CH_NUM-1:0] raw_lvl;

  // With PRESCALE=1 the prescaler sits at 0 and wraps every cycle, so pwm_tick stays high.
  assign pre_wrap = (pre_cnt == PRE_W'(PRESCALE - 1));

  // Shared free-running counters: blink source, prescaler and PWM step counter.
  always_ff @(posedge fpga_clk_in) begin
    if (!fpga_rst_n) begin
      led_cnt  <= '0;
      pre_cnt  <= '0;
      pwm_cnt  <= '0;
      pwm_tick <= 1'b0;
    end else begin
      led_cnt  <= led_cnt + CNT_W'(1);
      pre_cnt  <= pre_wrap ? '0 : pre_cnt + PRE_W'(1);
      pwm_tick <= pre_wrap;
      if (pre_wrap) begin
        pwm_cnt <= pwm_cnt + PWM_W'(1);
      end
    end
  end

  // Config register file; addresses with no matching channel are dropped.
  always_ff @(posedge fpga_clk_in) begin
    if (!fpga_rst_n) begin
      for (int i = 0; i < CH_NUM; i++) begin
        cfg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (cfg_wr_en && (cfg_addr == AW'(i))) begin
          cfg[i] <= cfg_wdata;
        end
      end
    end
  end

  // Readback mux; an address past the last channel returns zero.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (cfg_addr == AW'(i)) begin
        rd_sel = cfg[i];
      end
    end
  end

  // Per-channel level before polarity; a blink tap past the counter width shifts out to 0.
  always_comb begin
    raw_lvl = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      case (cfg[i][1:0])
        MODE_OFF:   raw_lvl[i] = 1'b0;
        MODE_ON:    raw_lvl[i] = 1'b1;
        MODE_BLINK: raw_lvl[i] = |(led_cnt & (CNT_W'(1) << cfg[i][6:2]));
        MODE_PWM:   raw_lvl[i] = (pwm_cnt < PWM_W'(cfg[i][15:8]));
        default:    raw_lvl[i] = 1'b0;
      endcase
    end
  end

  // Registered pin drive and readback; mode changes take effect on the next edge, unsynchronised.
  always_ff @(posedge fpga_clk_in) begin
    if (!fpga_rst_n) begin
      led_out   <= {CH_NUM{LED_ACTIVE_LOW}};
      cfg_rdata <= '0;
    end else begin
      led_out   <= raw_lvl ^ {CH_NUM{LED_ACTIVE_LOW}};
      cfg_rdata <= rd_sel;
    end
  end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Bench for led_pwm_ctrl: a 4-channel PRESCALE=2 instance and a 3-channel, 24-bit, active-low instance
// share one register port; outputs are predicted from the count of edges since reset release.
// Inputs change #1 after each rising edge and outputs are sampled at that same point.
module tb_led_pwm_ctrl;

  localparam int CH_A = 4;
  localparam int CW_A = 32;
  localparam int P_A  = 2;
  localparam int CH_B = 3;
  localparam int CW_B = 24;
  localparam int P_B  = 25;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [1:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata_a, rdata_b;
  logic        tick_a, tick_b;
  logic [3:0]  led_a;
  logic [2:0]  led_b;

  always #20 clk = ~clk;

  led_pwm_ctrl #(.CH_NUM(CH_A), .CNT_W(CW_A), .PRESCALE(P_A), .PWM_W(8), .LED_ACTIVE_LOW(1'b0)) dut_a (
    .fpga_clk_in(clk), .fpga_rst_n(rst_n), .cfg_wr_en(wr_en), .cfg_addr(addr),
    .cfg_wdata(wdata), .cfg_rdata(rdata_a), .pwm_tick(tick_a), .led_out(led_a)
  );

  led_pwm_ctrl #(.CH_NUM(CH_B), .CNT_W(CW_B), .PRESCALE(P_B), .PWM_W(8), .LED_ACTIVE_LOW(1'b1)) dut_b (
    .fpga_clk_in(clk), .fpga_rst_n(rst_n), .cfg_wr_en(wr_en), .cfg_addr(addr),
    .cfg_wdata(wdata), .cfg_rdata(rdata_b), .pwm_tick(tick_b), .led_out(led_b)
  );

  int errors = 0;
  int checks = 0;

  // Reference state: configuration as last written, and edges since reset release.
  logic [15:0] m_cfg_a [CH_A];
  logic [15:0] m_cfg_b [CH_B];
  longint      n_edges = 0;

  logic [3:0]  e_led_a;
  logic [2:0]  e_led_b;
  logic [15:0] e_rd_a, e_rd_b;
  logic        e_tick_a, e_tick_b;

  // After n edges: blink counter = n, PWM step = floor(n / prescale) mod 256.
  function automatic logic ref_level(logic [15:0] c, longint n, int cw, int p);
    int     sel;
    longint step_no;
    sel = int'(c[6:2]);
    case (c[1:0])
      2'b00: return 1'b0;
      2'b01: return 1'b1;
      2'b10: return (sel < cw) ? 1'(n >> sel) : 1'b0;
      default: begin
        step_no = (n / p) % 256;
        return (step_no < longint'(c[15:8]));
      end
    endcase
  endfunction

  task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Predict the outputs of the coming edge, advance the model, take the edge, compare.
  task automatic step();
    if (!rst_n) begin
      e_led_a  = 4'b0000;
      e_led_b  = 3'b111;
      e_rd_a   = 16'h0000;
      e_rd_b   = 16'h0000;
      e_tick_a = 1'b0;
      e_tick_b = 1'b0;
    end else begin
      for (int i = 0; i < CH_A; i++) e_led_a[i] = ref_level(m_cfg_a[i], n_edges, CW_A, P_A);
      for (int i = 0; i < CH_B; i++) e_led_b[i] = ~ref_level(m_cfg_b[i], n_edges, CW_B, P_B);
      e_rd_a   = (int'(addr) < CH_A) ? m_cfg_a[addr] : 16'h0000;
      e_rd_b   = (int'(addr) < CH_B) ? m_cfg_b[addr] : 16'h0000;
      e_tick_a = ((n_edges + 1) % P_A) == 0;
      e_tick_b = ((n_edges + 1) % P_B) == 0;
    end
    if (!rst_n) begin
      n_edges = 0;
      for (int i = 0; i < CH_A; i++) m_cfg_a[i] = 16'h0000;
      for (int i = 0; i < CH_B; i++) m_cfg_b[i] = 16'h0000;
    end else begin
      n_edges++;
      if (wr_en) begin
        if (int'(addr) < CH_A) m_cfg_a[addr] = wdata;
        if (int'(addr) < CH_B) m_cfg_b[addr] = wdata;
      end
    end
    @(posedge clk);
    #1;
    check("led_a", 16'(led_a), 16'(e_led_a));
    check("led_b", 16'(led_b), 16'(e_led_b));
    check("rdata_a", rdata_a, e_rd_a);
    check("rdata_b", rdata_b, e_rd_b);
    check("tick_a", 16'(tick_a), 16'(e_tick_a));
    check("tick_b", 16'(tick_b), 16'(e_tick_b));
  endtask

  task automatic write_cfg(logic [1:0] a, logic [15:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  task automatic count_ones(int ch, int cyc, output int ones);
    ones = 0;
    for (int k = 0; k < cyc; k++) begin
      step();
      ones += int'(led_a[ch]);
    end
  endtask

  int  ones;
  bit  seen_high;

  initial begin
    for (int i = 0; i < CH_A; i++) m_cfg_a[i] = 16'h0000;
    for (int i = 0; i < CH_B; i++) m_cfg_b[i] = 16'h0000;

    // Reset held with write strobe active: nothing may be stored.
    rst_n = 1'b0;
    wr_en = 1'b1;
    addr  = 2'd0;
    wdata = 16'hFFFF;
    repeat (3) step();
    rst_n = 1'b1;
    wr_en = 1'b0;
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      step();
    end
    step();

    // Static modes and readback.
    write_cfg(2'd0, 16'h0001);
    write_cfg(2'd1, 16'h0000);
    addr = 2'd0;
    repeat (3) step();
    check("ch0_on", 16'(led_a[0]), 16'h0001);

    // Blink on counter bit 3.
    write_cfg(2'd2, 16'h000E);
    repeat (40) step();

    // PWM duty sweeps on channel 3; any 512-cycle window is one full period at PRESCALE=2.
    write_cfg(2'd3, 16'h4003);
    repeat (4) step();
    count_ones(3, 512, ones);
    check("pwm_duty64_ones", 16'(ones), 16'd128);

    write_cfg(2'd3, 16'h0003);
    repeat (4) step();
    count_ones(3, 512, ones);
    check("pwm_duty0_ones", 16'(ones), 16'd0);

    write_cfg(2'd3, 16'hFF03);
    repeat (4) step();
    count_ones(3, 512, ones);
    check("pwm_duty255_ones", 16'(ones), 16'd510);

    // Mode change while the PWM output is high.
    write_cfg(2'd3, 16'h8003);
    seen_high = 1'b0;
    for (int k = 0; k < 600 && !seen_high; k++) begin
      step();
      if (led_a[3]) seen_high = 1'b1;
    end
    check("pwm_high_seen", 16'(seen_high), 16'h0001);
    write_cfg(2'd3, 16'h0000);
    step();
    check("mode_change_low", 16'(led_a[3]), 16'h0000);

    // Simultaneous write and read of address 1: old value, then new.
    addr = 2'd1;
    step();
    write_cfg(2'd1, 16'hA5A5);
    check("wr_rd_same_old", rdata_a, 16'h0000);
    step();
    check("wr_rd_same_new", rdata_a, 16'hA5A5);

    // Address 3 is out of range for the 3-channel instance.
    write_cfg(2'd3, 16'h1234);
    addr = 2'd3;
    repeat (2) step();
    check("oor_read_b", rdata_b, 16'h0000);

    // Blink tap 30 on a 24-bit counter stays at the inactive (high) level.
    write_cfg(2'd0, 16'h007A);
    repeat (10) step();
    check("b_sel30_inactive", 16'(led_b[0]), 16'h0001);

    // Reset in the middle of PWM activity.
    write_cfg(2'd3, 16'hFF03);
    repeat (21) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      step();
    end

    // Randomised writes, reads and occasional resets.
    for (int k = 0; k < 3000; k++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      wr_en = ($urandom_range(0, 3) == 0);
      addr  = 2'($urandom_range(0, 3));
      wdata = 16'($urandom);
      if ($urandom_range(0, 1) == 1) wdata[6:2] = 5'($urandom_range(0, 5));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
